// File: rtl/lns_sb_arbiter_if.sv
// Request/response and shared S_B bus for lns_sb_arbiter.
// slave = arbiter view, master = requester/S_B/consumer view.
interface lns_sb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int W       = 11,
  parameter int IDW     = 3
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0][W-1:0]   req_a;
  logic [NUM_REQ-1:0][W-1:0]   req_b;
  logic [NUM_REQ-1:0][1:0]     req_zero;   // {b_is_zero, a_is_zero}
  logic [W-1:0]                sb_z;
  logic [W-1:0]                sb_val;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [IDW-1:0]              resp_id;
  logic [W-1:0]                resp_r;
  logic                        resp_zero;
  logic                        resp_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_zero, sb_val, resp_ready,
    output req_ready, sb_z, resp_valid, resp_id, resp_r, resp_zero, resp_ovf
  );
  modport master (
    output req_valid, req_a, req_b, req_zero, sb_val, resp_ready,
    input  req_ready, sb_z, resp_valid, resp_id, resp_r, resp_zero, resp_ovf
  );
endinterface

// File: rtl/lns_sb_arbiter.sv
// Round-robin share of one combinational S_B evaluator; same-sign LNS add
// r = max(a,b) + sb(min-max) with zero bypass and +max saturation.
module lns_sb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 11,
  parameter int IDW     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  lns_sb_arbiter_if.slave bus
);
  localparam int         PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [W:0] MAXV = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0] MINV = {2'b11, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_EVAL, S_RESP} state_t;
  state_t r_state, w_nxt;

  logic [PW-1:0]      r_ptr, w_gnt, w_idx;
  logic               w_found, w_accept;
  logic [W-1:0]       r_a, r_b;
  logic [1:0]         r_zf;
  logic [IDW-1:0]     r_id;
  logic [W-1:0]       r_sb_z, r_resp_r;
  logic               r_resp_valid, r_resp_zero, r_resp_ovf;
  logic [IDW-1:0]     r_resp_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [W-1:0]       w_mx, w_mn, w_z, w_r;
  logic [W:0]         w_d, w_sum;
  logic               w_sat, w_ovf, w_zero;

  // first valid requester scanning upward from the rr pointer
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // next-state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_nxt = S_ALIGN;
      S_ALIGN: w_nxt = S_EVAL;
      S_EVAL:  w_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_mx  = ($signed(r_a) >= $signed(r_b)) ? r_a : r_b;
  assign w_mn  = ($signed(r_a) >= $signed(r_b)) ? r_b : r_a;
  assign w_d   = {w_mn[W-1], w_mn} - {w_mx[W-1], w_mx};
  assign w_z   = ($signed(w_d) < $signed(MINV)) ? MINV[W-1:0] : w_d[W-1:0];
  assign w_sum = {w_mx[W-1], w_mx} + {bus.sb_val[W-1], bus.sb_val};
  assign w_sat = $signed(w_sum) > $signed(MAXV);

  // outputs: grant strobe and the result to be registered on the EVAL edge
  always_comb begin
    w_req_ready = '0;
    if (rst_n && w_accept) w_req_ready[w_gnt] = 1'b1;
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    case (r_zf)
      2'b11: w_r = '0;
      2'b01: w_r = r_b;
      2'b10: w_r = r_a;
      default: begin
        w_r   = w_sat ? MAXV[W-1:0] : w_sum[W-1:0];
        w_ovf = w_sat;
      end
    endcase
    if (r_zf == 2'b11) w_zero = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_zf         <= '0;
      r_id         <= '0;
      r_sb_z       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_r     <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.req_a[w_gnt];
        r_b   <= bus.req_b[w_gnt];
        r_zf  <= bus.req_zero[w_gnt];
        r_id  <= IDW'(w_gnt);
        r_ptr <= (w_gnt == PW'(NUM_REQ-1)) ? '0 : w_gnt + PW'(1);
      end
      // sb_z is the only input of the shared S_B; it moves on ALIGN only
      if (r_state == S_ALIGN) r_sb_z <= w_z;
      if (r_state == S_EVAL) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= r_id;
        r_resp_r     <= w_r;
        r_resp_zero  <= w_zero;
        r_resp_ovf   <= w_ovf;
      end else if (r_state == S_RESP && bus.resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.sb_z       = r_sb_z;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_r     = r_resp_r;
  assign bus.resp_zero  = r_resp_zero;
  assign bus.resp_ovf   = r_resp_ovf;
endmodule

// File: tb/tb_lns_sb_arbiter.sv
// Directed bench for lns_sb_arbiter with a small table-driven S_B model.
module tb_lns_sb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lns_sb_arbiter_if #(.NUM_REQ(2), .W(11), .IDW(3)) bus ();

  lns_sb_arbiter #(.NUM_REQ(2), .W(11), .IDW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // S_B model: only the points the vectors use
  always_comb begin
    case (bus.sb_z)
      11'h000: bus.sb_val = 11'd128;
      11'h700: bus.sb_val = 11'd41;   // z = -256
      11'h400: bus.sb_val = 11'd0;    // z = -1024
      default: bus.sb_val = 11'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called at posedge+1 in IDLE; returns at posedge+1 back in IDLE
  task automatic run_op(input string tag, input int i, input logic [10:0] a, input logic [10:0] b,
                        input logic [1:0] zf, input logic [10:0] ez, input logic [10:0] er,
                        input logic ezero, input logic eovf, input int stall);
    int n;
    bus.resp_ready = (stall == 0);
    bus.req_valid = '0;
    bus.req_valid[i] = 1'b1;
    bus.req_a[i] = a;
    bus.req_b[i] = b;
    bus.req_zero[i] = zf;
    #1;
    n = 0;
    while (!bus.req_ready[i] && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, " grant"}, 32'(bus.req_ready), 32'(1) << i);
    @(posedge clk); #1;                        // ALIGN
    bus.req_valid = '0;
    bus.req_a[i] = 11'h2AA;
    bus.req_b[i] = 11'h155;
    bus.req_zero[i] = 2'b00;
    chk({tag, " rv@1"}, 32'(bus.resp_valid), 0);
    @(posedge clk); #1;                        // EVAL
    chk({tag, " sb_z"}, 32'(bus.sb_z), 32'(ez));
    chk({tag, " rv@2"}, 32'(bus.resp_valid), 0);
    @(posedge clk); #1;                        // RESP
    chk({tag, " rv@3"}, 32'(bus.resp_valid), 1);
    chk({tag, " r"}, 32'(bus.resp_r), 32'(er));
    chk({tag, " id"}, 32'(bus.resp_id), 32'(i));
    chk({tag, " zero"}, 32'(bus.resp_zero), 32'(ezero));
    chk({tag, " ovf"}, 32'(bus.resp_ovf), 32'(eovf));
    if (stall > 0) begin
      bus.req_valid = '1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk({tag, " stall rv"}, 32'(bus.resp_valid), 1);
        chk({tag, " stall r"}, 32'(bus.resp_r), 32'(er));
        chk({tag, " stall rdy"}, 32'(bus.req_ready), 0);
      end
      bus.req_valid = '0;
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;                        // IDLE
    chk({tag, " rv clr"}, 32'(bus.resp_valid), 0);
  endtask

  int acc_c[$];
  int acc_id[$];
  int n;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_zero = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(bus.req_ready), 0);
    chk("rst resp_valid", 32'(bus.resp_valid), 0);
    chk("rst sb_z", 32'(bus.sb_z), 0);
    chk("rst resp_r", 32'(bus.resp_r), 0);
    chk("rst resp_id", 32'(bus.resp_id), 0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1", 0, 11'd0, 11'd0, 2'b00, 11'h000, 11'd128, 1'b0, 1'b0, 0);
    run_op("t2", 1, 11'd256, 11'd0, 2'b00, 11'h700, 11'd297, 1'b0, 1'b0, 0);
    run_op("t3clamp", 0, 11'd1000, 11'h418, 2'b00, 11'h400, 11'd1000, 1'b0, 1'b0, 0);
    run_op("t3sat", 1, 11'd1000, 11'd1000, 2'b00, 11'h000, 11'd1023, 1'b0, 1'b1, 0);

    // both requesters streaming: grants alternate, one accept every 4 cycles
    bus.req_valid = 2'b11;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_zero = '0;
    #1;
    for (int c = 0; c < 18; c++) begin
      if (bus.req_ready != 2'b00) begin
        acc_c.push_back(c);
        acc_id.push_back(bus.req_ready[1] ? 1 : 0);
      end
      @(posedge clk); #2;
    end
    bus.req_valid = '0;
    chk("t4 accepts", 32'(acc_c.size()), 5);
    if (acc_c.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("t4 order", 32'(acc_id[k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) chk("t4 spacing", 32'(acc_c[k] - acc_c[k-1]), 4);
    end
    n = 0;
    while ((bus.resp_valid || n < 4) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4 drain", 32'(bus.resp_valid), 0);
    @(posedge clk); #1;

    run_op("t5az", 0, 11'd500, 11'd300, 2'b01, 11'h738, 11'd300, 1'b0, 1'b0, 0);
    run_op("t5zz", 1, 11'd5, 11'd7, 2'b11, 11'h7FE, 11'd0, 1'b1, 1'b0, 0);
    run_op("t5bz", 0, 11'h7CE, 11'd400, 2'b10, 11'h63E, 11'h7CE, 1'b0, 1'b0, 0);
    run_op("t6stall", 1, 11'd256, 11'd0, 2'b00, 11'h700, 11'd297, 1'b0, 1'b0, 5);

    // reset in EVAL: pointer was advanced to 1 by the req0 accept
    bus.req_valid = 2'b01;
    bus.req_a[0] = 11'd256;
    bus.req_b[0] = 11'd0;
    bus.req_zero[0] = 2'b00;
    #1;
    chk("t6 pre grant", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    chk("t6 eval sb_z", 32'(bus.sb_z), 32'(11'h700));
    rst_n = 1'b0;
    #1;
    chk("t6 rst sb_z", 32'(bus.sb_z), 0);
    chk("t6 rst resp_r", 32'(bus.resp_r), 0);
    chk("t6 rst resp_valid", 32'(bus.resp_valid), 0);
    chk("t6 rst resp_id", 32'(bus.resp_id), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("t6 post-rst grant", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6 post-rst done", 32'(bus.resp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
